// File: rtl/tftlcd_pio_pkg.sv
// rtl/tftlcd_pio_pkg.sv - shared register offsets and edge encodings for the TFT-LCD PIOs
package tftlcd_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_RAW     = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // True when a debounced transition to new_level counts as an event
  function automatic logic edge_match(input int edge_type, input logic new_level);
    case (edge_type)
      EDGE_RISING:  return new_level;
      EDGE_FALLING: return !new_level;
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/tftlcd_touch_in_pio_if.sv
// rtl/tftlcd_touch_in_pio_if.sv - Avalon-MM slave register bus for the touch input PIO
interface tftlcd_touch_in_pio_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/tftlcd_debounce_bit.sv
// rtl/tftlcd_debounce_bit.sv - one input line: 2-flop synchronizer, debounce counter, edge pulse
module tftlcd_debounce_bit
  import tftlcd_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int EDGE_TYPE       = EDGE_ANY
) (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic s_o,
  output logic d_o,
  output logic edge_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             settle;

  // Debounce: d follows s only after s has differed for DEBOUNCE_CYCLES straight cycles
  always_comb begin
    d_d    = d_q;
    cnt_d  = cnt_q;
    settle = 1'b0;
    if (sync_q == d_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      d_d    = sync_q;
      cnt_d  = '0;
      settle = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchronizer and debounce state; reset clears d so no event comes from it
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      d_q    <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= in_i;
      sync_q <= meta_q;
      d_q    <= d_d;
      cnt_q  <= cnt_d;
    end
  end

  assign s_o = sync_q;
  assign d_o = d_q;
  // Pulses in the cycle before d flips, so capture lands on the same edge as d
  assign edge_o = settle & edge_match(EDGE_TYPE, sync_q);

endmodule

// File: rtl/tftlcd_touch_in_pio.sv
// rtl/tftlcd_touch_in_pio.sv - Avalon-MM input PIO with debounce, edge capture and irq
module tftlcd_touch_in_pio
  import tftlcd_pio_pkg::*;
#(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int EDGE_TYPE       = EDGE_ANY
) (
  input  logic                  clk,
  input  logic                  reset,
  tftlcd_touch_in_pio_if.slave  bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [WIDTH-1:0] s_vec;
  logic [WIDTH-1:0] d_vec;
  logic [WIDTH-1:0] ev_vec;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] clr_bits;
  logic             wr_en;
  logic [31:0]      rd_data;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tftlcd_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .EDGE_TYPE       (EDGE_TYPE)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .in_i   (in_port[i]),
      .s_o    (s_vec[i]),
      .d_o    (d_vec[i]),
      .edge_o (ev_vec[i])
    );
  end

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign unused_wdata = &{1'b0, bus.writedata};

  // Register updates; a new event outranks a write-1-to-clear on the same bit
  always_comb begin
    mask_d    = mask_q;
    clr_bits  = '0;
    if (wr_en && bus.address == ADDR_IRQMASK) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end
    if (wr_en && bus.address == ADDR_EDGECAP) begin
      clr_bits = bus.writedata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~clr_bits) | ev_vec;
  end

  // Mask and capture registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q    <= '0;
      edgecap_q <= '0;
    end else begin
      mask_q    <= mask_d;
      edgecap_q <= edgecap_d;
    end
  end

  // Zero-wait read mux; bits above WIDTH read as zero
  always_comb begin
    rd_data = '0;
    case (bus.address)
      ADDR_DATA:    rd_data[WIDTH-1:0] = d_vec;
      ADDR_IRQMASK: rd_data[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: rd_data[WIDTH-1:0] = edgecap_q;
      ADDR_RAW:     rd_data[WIDTH-1:0] = s_vec;
      default:      rd_data = '0;
    endcase
  end

  assign bus.readdata = rd_data;
  assign irq          = |(edgecap_q & mask_q);

endmodule

// File: tb/tb_tftlcd_touch_in_pio.sv
// tb/tb_tftlcd_touch_in_pio.sv - scoreboard bench for tftlcd_touch_in_pio
module tb_tftlcd_touch_in_pio;

  localparam int SEL_IRQ = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] in_port;
  logic       irq;
  int         vectors = 0;
  int         miscompares = 0;
  exp_t       sb_q[$];

  tftlcd_touch_in_pio_if bus_if ();

  tftlcd_touch_in_pio #(
    .WIDTH           (3),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (16),
    .EDGE_TYPE       (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .in_port (in_port),
    .irq     (irq)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.sel < SEL_IRQ) begin
        bus_if.address = 2'(e.sel);
        #1;
        obs = bus_if.readdata;
      end else begin
        #1;
        obs = {31'b0, irq};
      end
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.address    = addr;
    bus_if.writedata  = data;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'h0;
  endtask

  initial begin
    reset             = 1'b1;
    in_port           = 3'b000;
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'h0;

    tick(2);
    expect_val("rst_irq", SEL_IRQ, 0);
    expect_val("rst_data", 0, 0);
    expect_val("rst_mask", 1, 0);
    expect_val("rst_cap", 2, 0);
    expect_val("rst_raw", 3, 0);
    drain();
    reset = 1'b0;
    tick(1);

    // bit0 rises and is held: s after edge 1, d and capture after edge 5
    in_port = 3'b001;
    tick(1);
    expect_val("lat_raw_e0", 3, 0);
    drain();
    tick(1);
    expect_val("lat_raw_e1", 3, 1);
    expect_val("lat_data_e1", 0, 0);
    drain();
    tick(3);
    expect_val("lat_data_e4", 0, 0);
    expect_val("lat_cap_e4", 2, 0);
    drain();
    tick(1);
    expect_val("lat_data_e5", 0, 1);
    expect_val("lat_cap_e5", 2, 1);
    expect_val("lat_irq_unmasked", SEL_IRQ, 0);
    drain();
    wr(2'd2, 32'h1);
    expect_val("cap_cleared", 2, 0);
    drain();

    // bit1 glitch lasting 3 synchronized cycles must not reach d
    in_port = 3'b011;
    tick(2);
    expect_val("glitch_raw", 3, 3);
    drain();
    tick(1);
    in_port = 3'b001;
    tick(6);
    expect_val("glitch_data", 0, 1);
    expect_val("glitch_cap", 2, 0);
    expect_val("glitch_raw_after", 3, 1);
    drain();

    // irq path: mask bit0, falling edge on bit0, then selective clears
    wr(2'd1, 32'hFFFF_FFF9);
    expect_val("mask_rd", 1, 1);
    drain();
    in_port = 3'b000;
    tick(5);
    expect_val("irq_before_cap", SEL_IRQ, 0);
    drain();
    tick(1);
    expect_val("irq_after_cap", SEL_IRQ, 1);
    expect_val("fall_cap", 2, 1);
    expect_val("fall_data", 0, 0);
    drain();
    wr(2'd2, 32'h2);
    expect_val("irq_clr_other", SEL_IRQ, 1);
    drain();
    wr(2'd2, 32'h1);
    expect_val("irq_clr_own", SEL_IRQ, 0);
    expect_val("cap_after_clr", 2, 0);
    drain();

    // clear write coinciding with the capture edge: the set wins
    in_port = 3'b001;
    tick(5);
    expect_val("race_cap_pre", 2, 0);
    drain();
    wr(2'd2, 32'h1);
    expect_val("race_cap", 2, 1);
    expect_val("race_data", 0, 1);
    expect_val("race_irq", SEL_IRQ, 1);
    drain();
    wr(2'd2, 32'h1);
    expect_val("race_cleared", 2, 0);
    drain();

    // reset while bit2's counter sits at 2
    in_port = 3'b101;
    tick(4);
    reset = 1'b1;
    tick(1);
    expect_val("mid_rst_data", 0, 0);
    expect_val("mid_rst_cap", 2, 0);
    expect_val("mid_rst_mask", 1, 0);
    drain();
    reset = 1'b0;
    tick(2);
    expect_val("post_rst_raw", 3, 5);
    expect_val("post_rst_cap_quiet", 2, 0);
    drain();
    tick(3);
    expect_val("post_rst_data_e4", 0, 0);
    drain();
    tick(1);
    expect_val("post_rst_data_e5", 0, 5);
    expect_val("post_rst_cap", 2, 5);
    expect_val("post_rst_irq", SEL_IRQ, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
